// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor in the 24 MHz reference domain.
// Optional WAIT_LOCK timeout/retry enabled by defining PLL_LOCK_TIMEOUT_EN.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 24,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 24000,
    parameter int CNT_W               = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       extlock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       locked,
    output logic [7:0] relock_count
);

    typedef enum logic [1:0] {
        RST_PLL,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("SYNC_STAGES must be at least 2");
        end
        if (PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1) begin : g_bad_cyc
            $error("cycle parameters must be at least 1");
        end
        if (longint'(PLL_RST_CYCLES) > CNT_MAX
            || longint'(LOCK_STABLE_CYCLES) > CNT_MAX) begin : g_bad_w
            $error("CNT_W too narrow for cycle parameters");
        end
        if (TO_EN && longint'(LOCK_TIMEOUT_CYCLES) > CNT_MAX) begin : g_bad_to
            $error("CNT_W too narrow for LOCK_TIMEOUT_CYCLES");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [7:0]             relock_q;
    logic [7:0]             relock_d;
    logic                   pll_reset_q;
    logic                   sys_reset_q;
    logic                   locked_q;
    logic                   lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], extlock};
    end

    always_comb begin
        state_d  = state_q;
        relock_d = relock_q;
        unique case (state_q)
            RST_PLL: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = RST_PLL;
                end
`endif
            end
            STABLE: begin
                // Lock loss wins over a simultaneous stable-count expiry.
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = RST_PLL;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            default: state_d = RST_PLL;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_d != state_q || state_q == RUN) begin
            cnt_d = '0;
        end else if (!TO_EN && state_q == WAIT_LOCK && cnt_q == '1) begin
            // Without a timeout the wait is unbounded, so pin the count.
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= RST_PLL;
            cnt_q       <= '0;
            relock_q    <= '0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            locked_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            relock_q    <= relock_d;
            pll_reset_q <= (state_d == RST_PLL);
            sys_reset_q <= (state_d != RUN);
            locked_q    <= (state_d == RUN);
        end
    end

    assign pll_reset    = pll_reset_q;
    assign sys_reset    = sys_reset_q;
    assign locked       = locked_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: power-up, glitch, lock loss,
// saturation, reset in RUN and WAIT_LOCK timeout (either build).
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       reset;
    logic       extlock;
    logic       pll_reset;
    logic       sys_reset;
    logic       locked;
    logic [7:0] relock_count;

    int   total = 0;
    int   bad   = 0;
    logic pll_seen = 1'b0;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic TO = 1'b1;
`else
    localparam logic TO = 1'b0;
`endif

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES        (2),
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .CNT_W              (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .extlock     (extlock),
        .pll_reset   (pll_reset),
        .sys_reset   (sys_reset),
        .locked      (locked),
        .relock_count(relock_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pll_seen = pll_seen | pll_reset;
        end
    endtask

    task automatic lose_and_relock();
        extlock = 1'b0;
        tick(7);
        extlock = 1'b1;
        tick(11);
    endtask

    initial begin
        reset   = 1'b1;
        extlock = 1'b0;

        // Power-up: reset held for 3 edges.
        tick(1);
        chk("rst_pll", 32'(pll_reset), 1);
        chk("rst_sys", 32'(sys_reset), 1);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_relock", 32'(relock_count), 0);
        tick(2);
        reset = 1'b0;
        chk("pwr_pll_e3", 32'(pll_reset), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("pwr_pll_hi", 32'(pll_reset), 1);
        end
        tick(1);
        chk("pwr_pll_lo", 32'(pll_reset), 0);
        chk("pwr_sys_wait", 32'(sys_reset), 1);
        tick(3);
        extlock = 1'b1;
        tick(10);
        chk("pwr_sys_pre", 32'(sys_reset), 1);
        chk("pwr_locked_pre", 32'(locked), 0);
        tick(1);
        chk("pwr_sys_rel", 32'(sys_reset), 0);
        chk("pwr_locked", 32'(locked), 1);
        chk("pwr_relock", 32'(relock_count), 0);

        // Lock loss in RUN.
        extlock = 1'b0;
        tick(2);
        chk("loss_locked_t2", 32'(locked), 1);
        tick(1);
        chk("loss_sys_t3", 32'(sys_reset), 1);
        chk("loss_locked_t3", 32'(locked), 0);
        chk("loss_pll_t3", 32'(pll_reset), 1);
        chk("loss_relock", 32'(relock_count), 1);
        tick(3);
        chk("loss_pll_t6", 32'(pll_reset), 1);
        tick(1);
        chk("loss_pll_t7", 32'(pll_reset), 0);

        // Glitch during STABLE at cnt=5.
        pll_seen = 1'b0;
        extlock  = 1'b1;
        tick(8);
        extlock = 1'b0;
        tick(1);
        extlock = 1'b1;
        tick(2);
        chk("gl_sys_mid", 32'(sys_reset), 1);
        tick(8);
        chk("gl_sys_pre", 32'(sys_reset), 1);
        chk("gl_locked_pre", 32'(locked), 0);
        tick(1);
        chk("gl_sys_rel", 32'(sys_reset), 0);
        chk("gl_locked", 32'(locked), 1);
        chk("gl_no_pll", 32'(pll_seen), 0);
        chk("gl_relock", 32'(relock_count), 1);

        // Reset in RUN with relock_count=3.
        lose_and_relock();
        lose_and_relock();
        chk("rr_relock3", 32'(relock_count), 3);
        chk("rr_locked", 32'(locked), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rr_pll", 32'(pll_reset), 1);
        chk("rr_sys", 32'(sys_reset), 1);
        chk("rr_locked0", 32'(locked), 0);
        chk("rr_relock0", 32'(relock_count), 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rr_pll_hi", 32'(pll_reset), 1);
        end
        tick(1);
        chk("rr_pll_lo", 32'(pll_reset), 0);
        tick(9);
        chk("rr_relocked", 32'(locked), 1);

        // Saturation over 300 lock losses.
        for (int i = 0; i < 300; i++) begin
            lose_and_relock();
            if (i == 0) chk("sat_first", 32'(relock_count), 1);
            if (i == 253) chk("sat_254", 32'(relock_count), 254);
            if (i == 254) chk("sat_255", 32'(relock_count), 255);
        end
        chk("sat_final", 32'(relock_count), 255);
        chk("sat_locked", 32'(locked), 1);

        // Timeout behaviour with extlock stuck low.
        extlock = 1'b0;
        reset   = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("to_relock_clr", 32'(relock_count), 0);
        chk("to_pll_r0", 32'(pll_reset), 1);
        tick(3);
        chk("to_pll_r3", 32'(pll_reset), 1);
        tick(1);
        chk("to_pll_r4", 32'(pll_reset), 0);
        pll_seen = 1'b0;
        tick(31);
        chk("to_pll_r35", 32'(pll_reset), 0);
        tick(1);
        chk("to_pll_r36", 32'(pll_reset), 32'(TO));
        tick(3);
        chk("to_pll_r39", 32'(pll_reset), 32'(TO));
        tick(1);
        chk("to_pll_r40", 32'(pll_reset), 0);
        tick(31);
        chk("to_pll_r71", 32'(pll_reset), 0);
        tick(1);
        chk("to_pll_r72", 32'(pll_reset), 32'(TO));
        chk("to_any_pulse", 32'(pll_seen), 32'(TO));
        chk("to_relock", 32'(relock_count), 0);
        chk("to_sys", 32'(sys_reset), 1);
        chk("to_locked", 32'(locked), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
